// File: rtl/secjmp_guard_ctrl.sv
// Jump-security guard between fetch and decode: squashes null-target jumps, counts them, locks the stream.
// Optional macro SECJMP_GUARD_TRAP_EN substitutes TRAP_WORD for squashed words instead of zero.
module secjmp_guard_ctrl #(
  parameter logic [5:0]  JMP_OPCODE  = 6'd2,
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned CNT_W       = 8,
  parameter logic [63:0] TRAP_WORD   = 64'h0000_0000_0000_000D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  input  logic             clear_i,
  output logic             viol_o,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             locked
);

`ifdef SECJMP_GUARD_TRAP_EN
  localparam logic [63:0] SQUASH_WORD = TRAP_WORD;
`else
  localparam logic [63:0] SQUASH_WORD = 64'h0;
`endif

  localparam logic [CNT_W-1:0] LOCK_THRESH_C = CNT_W'(LOCK_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              viol_q, viol_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0]        opcode;
  logic [25:0]       target;
  logic              is_viol;
  logic              accept_in;
  logic              drain_out;
  logic [CNT_W-1:0]  cnt_inc;
  logic              unused_trap;

  // Keeps TRAP_WORD referenced in the default build where it has no role.
  assign unused_trap = ^TRAP_WORD;

  assign opcode  = in_data[31:26];
  assign target  = in_data[25:0];
  assign is_viol = (opcode == JMP_OPCODE) && (target == 26'd0);

  assign in_ready  = (state_q == ST_LOCKED) || !valid_q || out_ready;
  assign accept_in = in_valid && in_ready;
  assign drain_out = valid_q && out_ready;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      data_q  <= 64'h0;
      valid_q <= 1'b0;
      viol_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      viol_q  <= viol_d;
      cnt_q   <= cnt_d;
    end
  end

  // In LOCKED, accepted words are dropped; only the existing output word may drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    viol_d  = 1'b0;
    cnt_d   = cnt_q;

    if (drain_out) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (accept_in) begin
          valid_d = 1'b1;
          data_d  = is_viol ? SQUASH_WORD : in_data;
          if (is_viol) begin
            viol_d = 1'b1;
            cnt_d  = cnt_inc;
            if (cnt_inc >= LOCK_THRESH_C) begin
              state_d = ST_LOCKED;
            end
          end
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Clear wins over a same-cycle violation: squash and pulse still happen, count and lock do not.
    if (clear_i) begin
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign viol_o    = viol_q;
  assign viol_cnt  = cnt_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_secjmp_guard_ctrl.sv
// Directed self-checking bench for secjmp_guard_ctrl with hand-computed expectations.
// Honours SECJMP_GUARD_TRAP_EN for the expected squash word.
module tb_secjmp_guard_ctrl;

  localparam int CNT_W = 8;

`ifdef SECJMP_GUARD_TRAP_EN
  localparam logic [63:0] SQ_WORD = 64'h0000_0000_0000_000D;
`else
  localparam logic [63:0] SQ_WORD = 64'h0;
`endif

  localparam logic [63:0] WORD_A = 64'h0000_0000_2000_0005;
  localparam logic [63:0] WORD_B = 64'h1234_0000_0800_0100;
  localparam logic [63:0] WORD_C = 64'hDEAD_BEEF_0800_0000;
  localparam logic [63:0] WORD_D = 64'hCAFE_0001_2000_0007;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             clear_i;
  logic             viol_o;
  logic [CNT_W-1:0] viol_cnt;
  logic             locked;

  int assertCount;
  int failCount;

  secjmp_guard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clear_i   (clear_i),
    .viol_o    (viol_o),
    .viol_cnt  (viol_cnt),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic driveInputs(input logic v, input logic [63:0] d, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear_i   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy, input logic clr);
    driveInputs(v, d, ordy, clr);
    tick();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    driveInputs(1'b0, 64'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_viol_o", viol_o, 0);
    checkOutput("rst_viol_cnt", viol_cnt, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Non-jump pass-through with one-cycle latency
    applyStimulus(1'b1, WORD_A, 1'b1, 1'b0);
    checkOutput("nj_valid", out_valid, 1);
    checkOutput("nj_data", out_data, WORD_A);
    checkOutput("nj_viol", viol_o, 0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    checkOutput("nj_drain_valid", out_valid, 0);

    // Legal jump passes unchanged
    applyStimulus(1'b1, WORD_B, 1'b1, 1'b0);
    checkOutput("lj_data", out_data, WORD_B);
    checkOutput("lj_viol", viol_o, 0);
    checkOutput("lj_cnt", viol_cnt, 0);

    // Null jump is squashed while the legal jump drains (no bubble)
    applyStimulus(1'b1, WORD_C, 1'b1, 1'b0);
    checkOutput("null_valid", out_valid, 1);
    checkOutput("null_data", out_data, SQ_WORD);
    checkOutput("null_viol", viol_o, 1);
    checkOutput("null_cnt", viol_cnt, 1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    checkOutput("null_viol_pulse_end", viol_o, 0);
    checkOutput("null_cnt_hold", viol_cnt, 1);
    checkOutput("null_drain_valid", out_valid, 0);

    // Backpressure holds the word and blocks input
    applyStimulus(1'b1, WORD_A, 1'b0, 1'b0);
    checkOutput("bp_load_valid", out_valid, 1);
    driveInputs(1'b1, WORD_D, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      tick();
      checkOutput("bp_hold_data", out_data, WORD_A);
      checkOutput("bp_hold_valid", out_valid, 1);
    end
    driveInputs(1'b1, WORD_D, 1'b1, 1'b0);
    #1;
    checkOutput("bp_release_in_ready", in_ready, 1);
    tick();
    checkOutput("b2b_valid", out_valid, 1);
    checkOutput("b2b_data", out_data, WORD_D);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    checkOutput("b2b_drain_valid", out_valid, 0);

    // Lockout after four violations
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    checkOutput("clr_cnt", viol_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, WORD_C, 1'b1, 1'b0);
      checkOutput("lock_cnt", viol_cnt, 64'(i + 1));
      checkOutput("lock_viol", viol_o, 1);
      checkOutput("lock_state", locked, (i == 3) ? 64'd1 : 64'd0);
    end
    driveInputs(1'b1, WORD_A, 1'b1, 1'b0);
    #1;
    checkOutput("lk_in_ready", in_ready, 1);
    tick();
    checkOutput("lk_no_valid", out_valid, 0);
    checkOutput("lk_no_viol", viol_o, 0);
    checkOutput("lk_cnt_hold", viol_cnt, 4);
    checkOutput("lk_locked", locked, 1);
    applyStimulus(1'b1, WORD_C, 1'b1, 1'b0);
    checkOutput("lk_null_no_viol", viol_o, 0);
    checkOutput("lk_null_cnt", viol_cnt, 4);
    checkOutput("lk_null_no_valid", out_valid, 0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
    checkOutput("unlock_locked", locked, 0);
    checkOutput("unlock_cnt", viol_cnt, 0);
    applyStimulus(1'b1, WORD_A, 1'b1, 1'b0);
    checkOutput("unlock_pass_valid", out_valid, 1);
    checkOutput("unlock_pass_data", out_data, WORD_A);
    checkOutput("unlock_pass_viol", viol_o, 0);

    // Clear coincident with the fourth violation
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, WORD_C, 1'b1, 1'b0);
    end
    checkOutput("co_cnt3", viol_cnt, 3);
    applyStimulus(1'b1, WORD_C, 1'b1, 1'b1);
    checkOutput("co_viol", viol_o, 1);
    checkOutput("co_cnt", viol_cnt, 0);
    checkOutput("co_locked", locked, 0);
    checkOutput("co_data", out_data, SQ_WORD);
    applyStimulus(1'b1, WORD_A, 1'b1, 1'b0);
    checkOutput("co_next_valid", out_valid, 1);
    checkOutput("co_next_data", out_data, WORD_A);

    // Asynchronous reset while a word is held
    applyStimulus(1'b1, WORD_C, 1'b1, 1'b0);
    checkOutput("mr_cnt_pre", viol_cnt, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    checkOutput("mr_valid_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid", out_valid, 0);
    checkOutput("mr_cnt", viol_cnt, 0);
    checkOutput("mr_locked", locked, 0);
    checkOutput("mr_in_ready", in_ready, 1);
    checkOutput("mr_data", out_data, 0);
    #10;
    rst_n = 1'b1;
    tick();
    checkOutput("mr_post_valid", out_valid, 0);
    checkOutput("mr_post_cnt", viol_cnt, 0);
    checkOutput("mr_post_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
